ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-outstanding AHB-Lite initiator (bus master) that turns a simple CPU-side request/response port into AHB-Lite SINGLE transfers.
- Sits between the core's data/instruction memory port and the AHB-Lite interconnect that feeds the memory-mapped peripherals (GPIO, timers, RAM).
- Drives the address and data phases non-pipelined, honours slave wait states, and reports the two-cycle ERROR response back to the CPU.

Parameters:
- ALIGN_CHECK, 1: when 1, a misaligned request completes with an error and issues no bus transfer.
- HPROT_VAL, 4'b0011: constant value driven on HPROT.

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset; synchronous, active-high.
- cpu_req  in  1  request valid; accepted when cpu_req & cpu_rdy.
- cpu_rdy  out  1  block can accept a request; equals (state==IDLE).
- cpu_we  in  1  1 = write, 0 = read.
- cpu_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as a misaligned/illegal request.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  write data, already placed on the correct byte lanes.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_done; 1 = bus error or misaligned request.
- cpu_rdata  out  32  read data, valid with cpu_done & !cpu_we_latched.
- HADDR  out  32  AHB address.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  {1'b0, size}.
- HTRANS  out  2  IDLE = 00, NONSEQ = 10.
- HBURST  out  3  constant 000 (SINGLE).
- HPROT  out  4  constant HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  32  write data.
- HRDATA  in  32  read data.
- HREADY  in  1  interconnect ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset values (sampled at the HCLK edge with HRESET=1):
  - state = IDLE.
  - HTRANS = 00, HADDR = 0, HWRITE = 0, HSIZE = 0, HWDATA = 0.
  - cpu_done = 0, cpu_err = 0, cpu_rdata = 0.
  - Reset applied in any state forces this next edge, with no completion pulse. A transfer aborted by reset is simply dropped.
- States: IDLE, ADDR, DATA, ERR2, MISAL.
- IDLE:
  - HTRANS = 00.
  - On cpu_req, latch addr, we, size and wdata.
  - Misaligned request: size==11, or (size==01 & addr[0]), or (size==10 & addr[1:0]!=0). With ALIGN_CHECK=1 a misaligned request goes to MISAL; otherwise it goes to ADDR.
  - Aligned request goes to ADDR.
- ADDR:
  - HTRANS = 10; HADDR, HWRITE and HSIZE come from the latched values.
  - If HREADY=1, go to DATA. Otherwise stay, holding every address-phase signal stable.
- DATA:
  - HTRANS = 00; HWDATA = latched wdata, held stable for the whole phase.
  - HREADY=1 & HRESP=0: cpu_done<=1, cpu_err<=0, cpu_rdata<=HRDATA (reads only; writes leave cpu_rdata unchanged), go to IDLE.
  - HREADY=0 & HRESP=1: first error cycle, go to ERR2.
  - HREADY=0 & HRESP=0: wait state, stay in DATA.
  - HREADY=1 & HRESP=1 (protocol violation): treated as error completion, same as ERR2 exit.
- ERR2:
  - HTRANS = 00.
  - On HREADY=1: cpu_done<=1, cpu_err<=1, go to IDLE. Otherwise stay.
- MISAL:
  - HTRANS = 00, no bus activity.
  - Next edge: cpu_done<=1, cpu_err<=1, go to IDLE.
- Completion pulses: cpu_done and cpu_err are registered, high for exactly one cycle, and deasserted every other cycle.
- Latency, accept edge to cpu_done high: 3 cycles with a zero-wait slave, +1 per wait state (HREADY low in DATA), 2 cycles for MISAL.
- Back-to-back: in the cycle cpu_done is high, state is IDLE, so a new request can be accepted in that same cycle. Minimum request spacing is 3 cycles.
- Inputs cpu_* are ignored outside IDLE; the latched values are never updated mid-transfer.
- HADDR, HWRITE and HSIZE hold their last value when idle. Only HTRANS marks validity.

Test Plan:
- Zero-wait read: req @0x40 word with HREADY=1 and HRDATA=0xCAFE0001 -> HTRANS=10 for 1 cycle, then cpu_done=1, cpu_err=0, cpu_rdata=0xCAFE0001 three cycles after accept.
- Write with 2 wait states: req we=1 @0x44, wdata=0x5, HREADY low for 2 DATA cycles -> HWDATA=0x5 stable across the whole data phase, cpu_done 5 cycles after accept, cpu_err=0.
- Error response: DATA cycle with HREADY=0, HRESP=1, then HREADY=1, HRESP=1 -> HTRANS=00 during both cycles, cpu_done=1 with cpu_err=1 after the second cycle, state returns to IDLE.
- Misaligned: word req @0x42 -> no HTRANS=10 ever, cpu_done & cpu_err two cycles after accept. Half req @0x42 -> normal transfer with HSIZE=001.
- Back-to-back: assert a second req during the cpu_done cycle -> it is accepted immediately, NONSEQ appears the next cycle, and the two dones are 3 cycles apart.
- Reset mid-op: HRESET=1 for one cycle while in DATA -> next cycle HTRANS=00, cpu_done=0, cpu_rdy=1. A subsequent read completes normally.

Source files
------------

// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite initiator: converts CPU request/response handshakes
// into non-pipelined SINGLE transfers, with optional alignment rejection.
module ahb_lite_master #(
  parameter bit         ALIGN_CHECK = 1'b1,
  parameter logic [3:0] HPROT_VAL   = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cpu_req,
  output logic        cpu_rdy,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR2,
    S_MISAL
  } state_t;

  state_t state;
  logic   misaligned;

  always_comb begin
    misaligned = (cpu_size == 2'b11) ||
                 ((cpu_size == 2'b01) && cpu_addr[0]) ||
                 ((cpu_size == 2'b10) && (cpu_addr[1:0] != 2'b00));
  end

  assign cpu_rdy   = (state == S_IDLE);
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  // HWDATA is loaded at accept so it is already stable when the data phase opens.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      HTRANS    <= TRANS_IDLE;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HSIZE     <= '0;
      HWDATA    <= '0;
      cpu_done  <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_done <= 1'b0;
      cpu_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            HADDR  <= cpu_addr;
            HWRITE <= cpu_we;
            HSIZE  <= {1'b0, cpu_size};
            HWDATA <= cpu_wdata;
            if (ALIGN_CHECK && misaligned) begin
              state <= S_MISAL;
            end else begin
              state  <= S_ADDR;
              HTRANS <= TRANS_NONSEQ;
            end
          end
        end
        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= TRANS_IDLE;
          end
        end
        S_DATA: begin
          if (HRESP) begin
            // HREADY high with ERROR is a protocol violation; finish as an error at once.
            if (HREADY) begin
              cpu_done <= 1'b1;
              cpu_err  <= 1'b1;
              state    <= S_IDLE;
            end else begin
              state <= S_ERR2;
            end
          end else if (HREADY) begin
            cpu_done <= 1'b1;
            if (!HWRITE) cpu_rdata <= HRDATA;
            state <= S_IDLE;
          end
        end
        S_ERR2: begin
          if (HREADY) begin
            cpu_done <= 1'b1;
            cpu_err  <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_MISAL: begin
          cpu_done <= 1'b1;
          cpu_err  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized self-checking bench for ahb_lite_master; a scheduled slave and a
// latency/response model derived from the transfer rules supply all expectations.
module tb_ahb_lite_master;

  logic        HCLK, HRESET;
  logic        cpu_req, cpu_rdy, cpu_we;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_done, cpu_err;
  logic [31:0] cpu_rdata;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_rdata = '0;

  ahb_lite_master dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cpu_req(cpu_req), .cpu_rdy(cpu_rdy), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .cpu_rdata(cpu_rdata), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic bit is_misal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Runs one transfer from cycle 0 (accept) on a scheduled slave. kind: 0 OKAY,
  // 1 two-cycle ERROR, 2 ERROR with HREADY high. Entry/exit at a negedge, DUT idle.
  task automatic run_txn(input bit we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdv,
                         input int aw, input int dw, input int e2w, input int kind,
                         input bit b2b, output int done_cyc, output bit got_err,
                         output logic [31:0] got_rdata, output int seq_err, output int wd_err);
    int  exp_done, first_data, last_c, d, e;
    bit  mis, in_addr, in_dphase;
    mis        = is_misal(size, addr);
    exp_done   = mis ? 2 : (kind == 1) ? aw + dw + e2w + 4 : aw + dw + 3;
    first_data = aw + 2;
    last_c     = b2b ? exp_done : exp_done + 1;
    done_cyc = -1; got_err = 1'b0; got_rdata = '0; seq_err = 0; wd_err = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge HCLK);
      if (c == 1) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_size = 2'($urandom);
        cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      in_addr   = !mis && (c <= aw + 1);
      in_dphase = !mis && (c >= first_data) && (c <= first_data + dw);
      if (HTRANS !== (in_addr ? 2'b10 : 2'b00)) seq_err++;
      if (cpu_rdy !== (c >= exp_done)) seq_err++;
      if (in_addr && (HADDR !== addr || HWRITE !== we || HSIZE !== {1'b0, size})) seq_err++;
      if (in_dphase && we && HWDATA !== wdata) wd_err++;
      if (cpu_done === 1'b1) begin
        if (c == exp_done) begin
          done_cyc = c; got_err = cpu_err; got_rdata = cpu_rdata;
        end else seq_err++;
      end else if (cpu_err !== 1'b0) seq_err++;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (in_addr) HREADY = (c > aw);
      else if (!mis && c >= first_data && c < exp_done) begin
        d = c - first_data;
        if (d < dw) HREADY = 1'b0;
        else if (d == dw) begin
          if (kind == 1) begin HREADY = 1'b0; HRESP = 1'b1; end
          else if (kind == 2) HRESP = 1'b1;
          else HRDATA = rdv;
        end else begin
          e = d - dw - 1;
          HRESP = 1'b1; HREADY = (e >= e2w);
        end
      end
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(negedge HCLK);
    n_checks++;
    if ({HTRANS, HADDR, HWRITE, HSIZE, HWDATA} !== '0) begin
      n_errors++;
      $display("FAIL reset_bus: got HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%b HWDATA=%h expected all 0",
               HTRANS, HADDR, HWRITE, HSIZE, HWDATA);
    end
    n_checks++;
    if ({cpu_done, cpu_err, cpu_rdata} !== '0 || cpu_rdy !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_cpu: got done=%b err=%b rdata=%h rdy=%b expected 0 0 0 1",
               cpu_done, cpu_err, cpu_rdata, cpu_rdy);
    end
    n_checks++;
    if (HBURST !== 3'b000 || HPROT !== 4'b0011 || HMASTLOCK !== 1'b0) begin
      n_errors++;
      $display("FAIL constants: got HBURST=%b HPROT=%b HMASTLOCK=%b expected 000 0011 0",
               HBURST, HPROT, HMASTLOCK);
    end
    HRESET = 1'b0;
    @(negedge HCLK);
  endtask

  task automatic test_zero_wait_read();
    int dc, se, we_; bit ge; logic [31:0] gr;
    run_txn(1'b0, 2'b10, 32'h40, 32'h0, 32'hCAFE0001, 0, 0, 0, 0, 1'b0, dc, ge, gr, se, we_);
    model_rdata = 32'hCAFE0001;
    n_checks++;
    if (dc !== 3 || ge !== 1'b0) begin
      n_errors++; $display("FAIL zero_read_done: got cycle %0d err %b expected 3 0", dc, ge);
    end
    n_checks++;
    if (gr !== 32'hCAFE0001) begin
      n_errors++; $display("FAIL zero_read_data: got %h expected cafe0001", gr);
    end
    n_checks++;
    if (se !== 0) begin
      n_errors++; $display("FAIL zero_read_bus: got %0d sequence errors expected 0", se);
    end
  endtask

  task automatic test_write_wait();
    int dc, se, we_; bit ge; logic [31:0] gr;
    run_txn(1'b1, 2'b10, 32'h44, 32'h5, 32'hDEAD0000, 0, 2, 0, 0, 1'b0, dc, ge, gr, se, we_);
    n_checks++;
    if (dc !== 5 || ge !== 1'b0) begin
      n_errors++; $display("FAIL write_wait_done: got cycle %0d err %b expected 5 0", dc, ge);
    end
    n_checks++;
    if (we_ !== 0 || se !== 0) begin
      n_errors++; $display("FAIL write_wait_bus: got hwdata errs %0d seq errs %0d expected 0 0", we_, se);
    end
    n_checks++;
    if (gr !== model_rdata) begin
      n_errors++; $display("FAIL write_keeps_rdata: got %h expected %h", gr, model_rdata);
    end
  endtask

  task automatic test_error();
    int dc, se, we_; bit ge; logic [31:0] gr;
    run_txn(1'b0, 2'b10, 32'h48, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 1'b0, dc, ge, gr, se, we_);
    n_checks++;
    if (dc !== 4 || ge !== 1'b1) begin
      n_errors++; $display("FAIL error_done: got cycle %0d err %b expected 4 1", dc, ge);
    end
    n_checks++;
    if (se !== 0 || gr !== model_rdata) begin
      n_errors++; $display("FAIL error_bus: got seq errs %0d rdata %h expected 0 %h", se, gr, model_rdata);
    end
  endtask

  task automatic test_misaligned();
    int dc, se, we_; bit ge; logic [31:0] gr;
    run_txn(1'b0, 2'b10, 32'h42, 32'h0, 32'h0, 0, 0, 0, 0, 1'b0, dc, ge, gr, se, we_);
    n_checks++;
    if (dc !== 2 || ge !== 1'b1 || se !== 0) begin
      n_errors++;
      $display("FAIL misal_word: got cycle %0d err %b seq errs %0d expected 2 1 0", dc, ge, se);
    end
    run_txn(1'b0, 2'b01, 32'h42, 32'h0, 32'h0000_BEEF, 0, 0, 0, 0, 1'b0, dc, ge, gr, se, we_);
    model_rdata = 32'h0000_BEEF;
    n_checks++;
    if (dc !== 3 || ge !== 1'b0 || se !== 0 || gr !== 32'h0000_BEEF) begin
      n_errors++;
      $display("FAIL half_aligned: got cycle %0d err %b seq errs %0d rdata %h expected 3 0 0 0000beef",
               dc, ge, se, gr);
    end
  endtask

  task automatic test_back_to_back();
    int dc, se, we_; bit ge; logic [31:0] gr;
    run_txn(1'b0, 2'b10, 32'h100, 32'h0, 32'hAAAA_0001, 0, 0, 0, 0, 1'b1, dc, ge, gr, se, we_);
    n_checks++;
    if (dc !== 3 || gr !== 32'hAAAA_0001) begin
      n_errors++; $display("FAIL b2b_first: got cycle %0d rdata %h expected 3 aaaa0001", dc, gr);
    end
    run_txn(1'b0, 2'b10, 32'h104, 32'h0, 32'hAAAA_0002, 0, 0, 0, 0, 1'b0, dc, ge, gr, se, we_);
    model_rdata = 32'hAAAA_0002;
    n_checks++;
    if (dc !== 3 || gr !== 32'hAAAA_0002 || se !== 0) begin
      n_errors++;
      $display("FAIL b2b_second: got cycle %0d rdata %h seq errs %0d expected 3 aaaa0002 0", dc, gr, se);
    end
  endtask

  task automatic test_reset_mid_op();
    int dc, se, we_, ndone; bit ge; logic [31:0] gr;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h80; HREADY = 1'b1; HRESP = 1'b0;
    @(negedge HCLK);
    cpu_req = 1'b0;
    @(negedge HCLK);
    HREADY = 1'b0; HRESET = 1'b1;
    @(negedge HCLK);
    n_checks++;
    if (HTRANS !== 2'b00 || cpu_done !== 1'b0 || cpu_rdy !== 1'b1 || cpu_rdata !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid_op: got HTRANS=%b done=%b rdy=%b rdata=%h expected 00 0 1 0",
               HTRANS, cpu_done, cpu_rdy, cpu_rdata);
    end
    model_rdata = '0;
    HRESET = 1'b0; HREADY = 1'b1;
    ndone = 0;
    repeat (4) begin
      @(negedge HCLK);
      if (cpu_done === 1'b1 || HTRANS !== 2'b00) ndone++;
    end
    n_checks++;
    if (ndone !== 0) begin
      n_errors++; $display("FAIL reset_drop: got %0d stray cycles expected 0", ndone);
    end
    run_txn(1'b0, 2'b10, 32'h84, 32'h0, 32'h7777_0001, 0, 0, 0, 0, 1'b0, dc, ge, gr, se, we_);
    model_rdata = 32'h7777_0001;
    n_checks++;
    if (dc !== 3 || ge !== 1'b0 || gr !== 32'h7777_0001 || se !== 0) begin
      n_errors++;
      $display("FAIL after_reset_read: got cycle %0d err %b rdata %h seq %0d expected 3 0 77770001 0",
               dc, ge, gr, se);
    end
  endtask

  task automatic test_random();
    int dc, se, we_, aw, dw, e2w, kind, exp_done; bit ge, we, mis, b2b, exp_err;
    logic [1:0] size; logic [31:0] addr, wdata, rdv, gr;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); size = 2'($urandom); addr = $urandom & 32'h0000_0FFF;
      if ($urandom_range(3, 0) != 0) addr[1:0] = 2'b00;
      wdata = $urandom; rdv = $urandom;
      aw = $urandom_range(2, 0); dw = $urandom_range(3, 0); e2w = $urandom_range(2, 0);
      kind = ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0;
      b2b = 1'($urandom);
      mis = is_misal(size, addr);
      exp_done = mis ? 2 : (kind == 1) ? aw + dw + e2w + 4 : aw + dw + 3;
      exp_err  = mis || (kind != 0);
      if (!exp_err && !we) model_rdata = rdv;
      run_txn(we, size, addr, wdata, rdv, aw, dw, e2w, kind, b2b, dc, ge, gr, se, we_);
      n_checks++;
      if (dc !== exp_done) begin
        n_errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, dc, exp_done);
      end
      n_checks++;
      if (ge !== exp_err) begin
        n_errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, ge, exp_err);
      end
      n_checks++;
      if (gr !== model_rdata) begin
        n_errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, gr, model_rdata);
      end
      n_checks++;
      if (se !== 0 || we_ !== 0) begin
        n_errors++; $display("FAIL rand_bus[%0d]: got seq %0d hwdata %0d expected 0 0", i, se, we_);
      end
    end
  endtask

  initial begin
    HRESET = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_size = 2'b00;
    cpu_addr = '0; cpu_wdata = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    test_reset();
    test_zero_wait_read();
    test_write_wait();
    test_error();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
